// File: rtl/core_writeback_stage.sv
// core_writeback_stage
//   Drives the core register file's single write port. Each cycle it picks one
//   result, in priority order: ALU, then the long-latency FIFO head, then an
//   LSU result passed straight through. The chosen result is registered onto
//   rf_we/rf_write_addr/rf_write_data. A 32-bit pending-write scoreboard lets
//   decode stall reads of registers whose writes have not landed yet.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   issue_valid/issue_rd           issued instruction that will write issue_rd
//   alu_valid/alu_rd/alu_data      single-cycle result, always accepted
//   lsu_valid/lsu_ready/lsu_rd/lsu_data
//                                  long-latency result, valid/ready handshake
//   rf_we/rf_write_addr/rf_write_data
//                                  registered register-file write port
//   chk_addr0/1, chk_busy0/1       scoreboard lookups for decode (combinational)
//   fifo_count                     number of buffered long-latency results
module core_writeback_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [DATA_WIDTH-1:0]         lsu_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_write_addr,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  input  logic [4:0]                    chk_addr0,
  input  logic [4:0]                    chk_addr1,
  output logic                          chk_busy0,
  output logic                          chk_busy1,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [4:0]            fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [31:0]           busy_q;
  logic [31:0]           busy_d;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  lsu_xfer;
  logic                  alu_sel;
  logic                  fifo_pop;
  logic                  lsu_bypass;
  logic                  fifo_push;
  logic                  sel_valid;
  logic [4:0]            sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  // Based on the registered count only, so ready cannot rise in the same
  // cycle a full FIFO pops.
  assign lsu_ready  = !fifo_full && !rst;
  assign lsu_xfer   = lsu_valid && lsu_ready;

  // x0 ALU results are dropped and leave the port free for the FIFO head.
  assign alu_sel    = alu_valid && (alu_rd != 5'd0);
  assign fifo_pop   = !alu_sel && !fifo_empty;
  assign lsu_bypass = !alu_sel && fifo_empty && lsu_xfer && (lsu_rd != 5'd0);
  assign fifo_push  = lsu_xfer && (lsu_rd != 5'd0) && !lsu_bypass;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_sel) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (fifo_pop) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd_q[rd_ptr_q];
      sel_data  = fifo_data_q[rd_ptr_q];
    end else if (lsu_bypass) begin
      sel_valid = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rd_q[wr_ptr_q]   <= lsu_rd;
      fifo_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (fifo_push && !fifo_pop)      count_q <= count_q + CW'(1);
      else if (fifo_pop && !fifo_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we         <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else begin
      rf_we <= sel_valid;
      if (sel_valid) begin
        rf_write_addr <= sel_rd;
        rf_write_data <= sel_data;
      end
    end
  end

  // Clear lands on the same edge the register file stores the data; a new
  // issue to the same rd at that edge must survive, so set is applied last.
  always_comb begin
    busy_d = busy_q;
    if (rf_we) busy_d[rf_write_addr] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign chk_busy0  = busy_q[chk_addr0];
  assign chk_busy1  = busy_q[chk_addr1];
  assign fifo_count = count_q;

endmodule

// File: doc/core_writeback_stage.md
# core_writeback_stage

Writer-side block for the core register file's single write port. Each cycle it arbitrates between single-cycle ALU results and backpressured long-latency (load/mul-div) results. Long-latency results are buffered in a small FIFO, and the block drives registered write-enable, address and data into the register file. A 32-entry pending-write scoreboard is kept so decode can stall reads of registers whose writes have not yet landed.

## Interface
- DATA_WIDTH, 32 (core_pkg): result/register width
- FIFO_DEPTH, 2: long-latency result buffer entries (power of two, >=2)

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  instruction issued that will write issue_rd
- issue_rd  in  5  destination of issued instruction
- alu_valid  in  1  ALU result present (no backpressure, always accepted)
- alu_rd  in  5  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  long-latency result present
- lsu_ready  out  1  block accepts long-latency result this cycle
- lsu_rd  in  5  long-latency destination
- lsu_data  in  DATA_WIDTH  long-latency result
- rf_we  out  1  register-file write enable (registered)
- rf_write_addr  out  5  register-file write address (registered)
- rf_write_data  out  DATA_WIDTH  register-file write data (registered)
- chk_addr0, chk_addr1  in  5 each  decode read addresses to check
- chk_busy0, chk_busy1  out  1 each  addressed register has a pending write (combinational)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered long-latency results

## Operation
- LSU handshake: transfer on lsu_valid && lsu_ready; lsu_ready = !fifo_full && !rst. lsu_ready does not rise in the same cycle as a pop from a full FIFO.
- Per-cycle write-port selection, in priority order:
  1. ALU, if alu_valid && alu_rd != 0.
  2. Otherwise the FIFO head, if the FIFO is non-empty.
  3. Otherwise bypass: an LSU transfer this cycle with the FIFO empty goes straight to the port and is not pushed.
- An LSU transfer that is not bypassed is pushed to the FIFO tail. FIFO push and pop in the same cycle are allowed; count is unchanged.
- Selected result is registered into rf_we=1, rf_write_addr, rf_write_data at the next edge. With no selection, rf_we=0 and address/data hold their previous values.
- x0 handling:
  - ALU result with rd=0 is discarded and does not block the FIFO drain.
  - LSU transfer with rd=0 completes its handshake and is discarded, never pushed.
  - A FIFO entry never has rd=0.
- Ordering: FIFO drains strictly in order. ALU may overtake buffered LSU results; the issuer guarantees no two in-flight writes share an rd.
- Scoreboard (32 busy bits, bit 0 constant 0):
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd] at the next edge.
  - Clear: rf_we=1 clears busy[rf_write_addr] at the next edge, i.e. the same edge the register file stores the data.
  - Same rd set and cleared at the same edge: set wins.
- chk_busyN = busy[chk_addrN]; always 0 for address 0.
- Issuing to an rd whose busy bit is set is illegal; the bench asserts on it.

## Timing
- Reset (rst high at an edge): rf_we=0, rf_write_addr=0, rf_write_data=0, all busy bits 0, FIFO empty, fifo_count=0, lsu_ready=0 while rst is high. Reset mid-operation drops all buffered results and pending bits.
- ALU latency: alu_valid at edge N, rf_we=1 after edge N+1. Register file written at edge N+2; chk_busy drops after edge N+2.
- LSU bypass latency matches the ALU path (1 cycle to rf_we).
- Buffered LSU: rf_we follows the first cycle with no valid ALU, in FIFO order.
- Full FIFO with continuous ALU traffic: lsu_ready stays 0 indefinitely (ALU starvation of the LSU path is allowed).
- At most one rf_we per cycle.
- issue_valid at edge N: chk_busy=1 from cycle N+1.

## Test plan
- Reset then ALU result rd=5, data 0xDEADBEEF at cycle 1 -> rf_we=1, addr 5, data 0xDEADBEEF in cycle 2 only. issue of rd=5 before it -> chk_busy0 (chk_addr0=5) high until edge after rf_we.
- LSU rd=7, data 0x11 alone, FIFO empty -> bypass, rf_we next cycle, fifo_count stays 0.
- Simultaneous ALU rd=3 and LSU rd=4 for 3 cycles (distinct rds) -> ALU writes 3 cycles, FIFO fills to 2, lsu_ready=0 on the third cycle. Once ALU stops, LSU results drain in order on consecutive cycles.
- ALU rd=0 with FIFO holding rd=9 -> rd=9 written next cycle. LSU rd=0 -> handshake completes, no rf_we, no push.
- Issue rd=12 while rf_we is clearing rd=12 at the same edge -> busy[12]=1 afterwards.
- Assert rst with 2 FIFO entries and 3 busy bits set -> next cycle rf_we=0, fifo_count=0, all chk_busy 0, lsu_ready=1 after rst falls.
